// File: rtl/ssd_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment
// patterns {a..g} and the all-anodes-off value.
package ssd_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [7:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern {a..g}.
module hex_to_7seg
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 8-digit hex display driver with registered pin outputs.
// Optional leading-zero blanking is enabled by defining SSD_ZERO_BLANK_EN.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_valid,
    input  logic [31:0] disp_data,
    input  logic        disp_en,
    output logic [7:0]  Anode_Activate,
    output logic [6:0]  LED_out
);

    localparam int              CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [31:0]      shadow_reg, shadow_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       digit_reg, digit_next;
    logic [7:0]       anode_reg, anode_next;
    logic [6:0]       led_reg, led_next;

    logic [3:0]       nibble;
    logic [6:0]       seg_pattern;
    logic             blank;

    always_comb begin
        shadow_next = disp_valid ? disp_data : shadow_reg;
        cnt_next    = cnt_reg + 1'b1;
        digit_next  = digit_reg;
        if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            digit_next = (digit_reg == DIGIT_LAST) ? 3'd0 : digit_reg + 3'd1;
        end
    end

    // Outputs follow the pre-increment digit and the already-captured shadow.
    assign nibble = shadow_reg[{digit_reg, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg    (seg_pattern)
    );

`ifdef SSD_ZERO_BLANK_EN
    // upper_zero[i]: shadow nibbles i..NUM_DIGITS-1 are all zero.
    logic [MAX_DIGITS-1:0] upper_zero;

    for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_upper_zero
        if (gi >= NUM_DIGITS) begin : g_unused
            assign upper_zero[gi] = 1'b1;
        end else if (gi == NUM_DIGITS - 1) begin : g_top
            assign upper_zero[gi] = (shadow_reg[4*gi +: 4] == 4'h0);
        end else begin : g_chain
            assign upper_zero[gi] = (shadow_reg[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
        end
    end

    assign blank = (digit_reg != 3'd0) && upper_zero[digit_reg];
`else
    assign blank = 1'b0;
`endif

    // Anodes beyond NUM_DIGITS are tied off so they can never light.
    for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_anode
        if (gi < NUM_DIGITS) begin : g_used
            assign anode_next[gi] = ~(disp_en && (digit_reg == 3'(gi)));
        end else begin : g_off
            assign anode_next[gi] = 1'b1;
        end
    end

    always_comb begin
        led_next = SEG_BLANK;
        if (disp_en && !blank) begin
            led_next = seg_pattern;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_reg <= '0;
            cnt_reg    <= '0;
            digit_reg  <= '0;
            anode_reg  <= ANODE_OFF;
            led_reg    <= SEG_BLANK;
        end else begin
            shadow_reg <= shadow_next;
            cnt_reg    <= cnt_next;
            digit_reg  <= digit_next;
            anode_reg  <= anode_next;
            led_reg    <= led_next;
        end
    end

    assign Anode_Activate = anode_reg;
    assign LED_out        = led_reg;

endmodule
